cve2_hpm_unit: RTL and testbench
================================

CVE2_HPM_UNIT -- requirements
Module: cve2_hpm_unit

Interface
REQ-001 SHALL have parameter NUM_HPM, default 2, giving the number of implemented mhpmcounter3..(3+NUM_HPM-1), legal range 0..29.
REQ-002 SHALL have parameter CNT_WIDTH, default 40, giving the physical width of every counter, legal range 33..64.
REQ-003 SHALL have parameter NUM_EVENTS, default 16, giving the width of the event bus, legal range 1..32.
REQ-004 SHALL be clocked by clk_i, input, 1: the one clock; rising edge.
REQ-005 SHALL reset on rst_i, input, 1: asynchronous, active-high.
REQ-006 SHALL accept csr_addr_i, input, 12: CSR number using the csr_num_e encoding.
REQ-007 SHALL accept csr_we_i, input, 1: write strobe, one cycle.
REQ-008 SHALL accept csr_wdata_i, input, 32: final write value, already computed from csr_op_e by the caller.
REQ-009 SHALL drive csr_rdata_o, output, 32: combinational read data.
REQ-010 SHALL drive csr_hit_o, output, 1: high when csr_addr_i decodes to a CSR this block owns.
REQ-011 SHALL accept instr_ret_i, input, 1: one instruction retired this cycle.
REQ-012 SHALL accept event_i, input, NUM_EVENTS: per-cycle event pulses.
REQ-013 SHALL accept stopcount_i, input, 1: debug-mode count freeze.
REQ-014 SHALL drive irq_ovf_o, output, 1: counter-overflow interrupt (see Configuration).

Function
REQ-015 SHALL own mcycle/h, minstret/h, mhpmcounter3..31/h, mhpmevent3..31 and mcountinhibit; every other address gives csr_hit_o=0 and csr_rdata_o=0.
REQ-016 SHALL increment mcycle by 1 per cycle, minstret by 1 when instr_ret_i=1, and hpm counter k by 1 when (event_i & mhpmevent_k[NUM_EVENTS-1:0]) != 0.
REQ-017 SHALL suppress all increments while stopcount_i=1 or the matching mcountinhibit bit is 1.
REQ-018 SHALL update a counter on the cycle after the triggering edge, with no increment skipping or doubling.
REQ-019 SHALL map a low-half write to counter bits [31:0] and a high-half write to bits [CNT_WIDTH-1:32], discarding any excess write bits.
REQ-020 SHALL read high-half bits at or above CNT_WIDTH-32 as 0.
REQ-021 SHALL give a write priority over an increment to the same counter in the same cycle: the written half takes the write value, the other half holds, and there is no increment that cycle.
REQ-022 SHALL wrap a counter from all-ones (CNT_WIDTH bits) to 0.
REQ-023 SHALL treat unimplemented counters and events (index >= 3+NUM_HPM) as read-zero and write-ignored, with csr_hit_o=1.
REQ-024 SHALL keep mcountinhibit bit 1 (time) and the bits of unimplemented counters hard-wired to 0.
REQ-025 SHALL store only NUM_EVENTS bits of each mhpmevent and read the remaining bits as 0.

Reset
REQ-026 SHALL reset all counters, mhpmevent and mcountinhibit to 0.
REQ-027 SHALL hold csr_rdata_o=0 and irq_ovf_o=0 while rst_i=1 (csr_rdata_o is the ungated mux when rst_i=0).
REQ-028 SHALL, on reset asserted mid-count, clear state immediately with no completion of the pending increment.

Configuration
REQ-029 SHALL, with CVE2_HPM_OVF_IRQ_EN defined, hold a sticky overflow flag per implemented counter that sets on wrap and clears on any write to either half of that counter (a write in the wrap cycle wins), and drive irq_ovf_o = OR of all flags.
REQ-030 SHALL, with CVE2_HPM_OVF_IRQ_EN undefined, contain no flags and tie irq_ovf_o to 0.

Structure
REQ-031 SHALL place the hpm event-index enum (hpm_event_e), HPM_MAX_COUNTERS=29 and the CNT_WIDTH legal bounds in cve2_pkg, reusing the existing csr_num_e entries.
REQ-032 SHALL instantiate one sub-module, cve2_counter (parameter WIDTH; increment, low/high write ports, value and wrap outputs), per counter.

Verification
REQ-033 SHALL verify: reset, then 10 idle cycles -> mcycle=10, minstret=0, csr_rdata_o on mcycleh=0.
REQ-034 SHALL verify: CNT_WIDTH=40, write mcycleh=0xFFFFFFFF then read -> 0x000000FF; with mcycle=0xFFFFFFFF, after 1 cycle -> counter=0, irq_ovf_o=1 when the macro is defined and 0 when it is not.
REQ-035 SHALL verify: mhpmevent3=0x5 with event_i=0x4 for 3 cycles -> mhpmcounter3=3; mcountinhibit bit3=1 -> no further change.
REQ-036 SHALL verify: a write to minstret=0x100 in the same cycle as instr_ret_i=1 -> reads 0x100 the next cycle, not 0x101.
REQ-037 SHALL verify: NUM_HPM=2, write mhpmcounter7=0x1234 -> reads 0, csr_hit_o=1; write mcountinhibit=0xFFFFFFFF -> reads 0x0000001D.
REQ-038 SHALL verify: rst_i asserted between clock edges mid-count -> all outputs 0 immediately, with no clock edge needed.

Source files
------------

// File: rtl/cve2_pkg.sv
// Shared CSR numbering and performance-counter constants for the cve2 core.
package cve2_pkg;

  typedef enum logic [11:0] {
    CSR_MCOUNTINHIBIT  = 12'h320,
    CSR_MHPMEVENT3     = 12'h323,
    CSR_MHPMEVENT31    = 12'h33F,
    CSR_MCYCLE         = 12'hB00,
    CSR_MINSTRET       = 12'hB02,
    CSR_MHPMCOUNTER3   = 12'hB03,
    CSR_MHPMCOUNTER31  = 12'hB1F,
    CSR_MCYCLEH        = 12'hB80,
    CSR_MINSTRETH      = 12'hB82,
    CSR_MHPMCOUNTER3H  = 12'hB83,
    CSR_MHPMCOUNTER31H = 12'hB9F
  } csr_num_e;

  // Counter position inside the CSR windows; also the mcountinhibit bit index.
  typedef enum logic [4:0] {
    HPM_EVT_CYCLE   = 5'd0,
    HPM_EVT_TIME    = 5'd1,
    HPM_EVT_INSTRET = 5'd2,
    HPM_EVT_HPM3    = 5'd3
  } hpm_event_e;

  localparam int unsigned HPM_MAX_COUNTERS = 29;
  localparam int unsigned CNT_WIDTH_MIN    = 33;
  localparam int unsigned CNT_WIDTH_MAX    = 64;

  // Physical counter slot i (0=mcycle, 1=minstret, 2..=hpm3..) to CSR index.
  function automatic logic [4:0] cnt_csr_idx(int i);
    return (i == 0) ? HPM_EVT_CYCLE : 5'(i + 1);
  endfunction

endpackage

// File: rtl/cve2_counter.sv
// One performance counter: CSR half writes take priority over increment.
module cve2_counter #(
  parameter int unsigned WIDTH = 40
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             inc_i,
  input  logic             we_lo_i,
  input  logic             we_hi_i,
  input  logic [31:0]      wdata_i,
  output logic [WIDTH-1:0] value_o,
  output logic             wrap_o
);

  logic [WIDTH-1:0] cnt_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)        cnt_q <= '0;
    else if (we_lo_i) cnt_q[31:0] <= wdata_i;
    else if (we_hi_i) cnt_q[WIDTH-1:32] <= wdata_i[WIDTH-33:0];
    else if (inc_i)   cnt_q <= cnt_q + WIDTH'(1);
  end

  assign value_o = cnt_q;
  assign wrap_o  = inc_i & ~we_lo_i & ~we_hi_i & (&cnt_q);

endmodule

// File: rtl/cve2_hpm_unit.sv
// Machine counters (mcycle, minstret, mhpmcounterN), events and mcountinhibit.
// Define CVE2_HPM_OVF_IRQ_EN to add sticky per-counter overflow flags on irq_ovf_o.
module cve2_hpm_unit
  import cve2_pkg::*;
#(
  parameter int unsigned NUM_HPM    = 2,
  parameter int unsigned CNT_WIDTH  = 40,
  parameter int unsigned NUM_EVENTS = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [11:0]           csr_addr_i,
  input  logic                  csr_we_i,
  input  logic [31:0]           csr_wdata_i,
  output logic [31:0]           csr_rdata_o,
  output logic                  csr_hit_o,
  input  logic                  instr_ret_i,
  input  logic [NUM_EVENTS-1:0] event_i,
  input  logic                  stopcount_i,
  output logic                  irq_ovf_o
);

  localparam int unsigned NCNT = 2 + NUM_HPM;
  localparam int unsigned NEVQ = (NUM_HPM > 0) ? NUM_HPM : 1;

  logic [NCNT-1:0][CNT_WIDTH-1:0]  cnt_val;
  logic [NCNT-1:0]                 cnt_inc, cnt_wrap, we_lo, we_hi, inh_q;
  logic [NEVQ-1:0][NUM_EVENTS-1:0] evt_q;
  logic [NEVQ-1:0]                 evt_we;
  logic [31:0]                     rdata, inh_rd;
  logic [4:0]                      idx;
  logic                            is_cnt, is_evt, is_inh;

  // Counter windows at 0xB00/0xB80 (index 1 is time, owned elsewhere); events at 0x323..
  assign idx    = csr_addr_i[4:0];
  assign is_cnt = ((csr_addr_i & 12'hF60) == CSR_MCYCLE) && (idx != HPM_EVT_TIME);
  assign is_evt = ((csr_addr_i & 12'hFE0) == CSR_MCOUNTINHIBIT) && (idx >= HPM_EVT_HPM3);
  assign is_inh = (csr_addr_i == CSR_MCOUNTINHIBIT);

  always_comb begin
    rdata  = '0;
    inh_rd = '0;
    we_lo  = '0;
    we_hi  = '0;
    evt_we = '0;
    for (int i = 0; i < NCNT; i++) begin
      inh_rd[cnt_csr_idx(i)] = inh_q[i];
      if (is_cnt && idx == cnt_csr_idx(i)) begin
        rdata    = csr_addr_i[7] ? 32'(cnt_val[i] >> 32) : cnt_val[i][31:0];
        we_lo[i] = csr_we_i & ~csr_addr_i[7];
        we_hi[i] = csr_we_i & csr_addr_i[7];
      end
    end
    for (int k = 0; k < NUM_HPM; k++) begin
      if (is_evt && idx == 5'(k + 3)) begin
        rdata     = 32'(evt_q[k]);
        evt_we[k] = csr_we_i;
      end
    end
    if (is_inh) rdata = inh_rd;
  end

  assign csr_hit_o   = is_cnt | is_evt | is_inh;
  assign csr_rdata_o = rst_i ? 32'h0 : rdata;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      evt_q <= '0;
      inh_q <= '0;
    end else begin
      for (int k = 0; k < NUM_HPM; k++)
        if (evt_we[k]) evt_q[k] <= csr_wdata_i[NUM_EVENTS-1:0];
      if (is_inh && csr_we_i)
        for (int i = 0; i < NCNT; i++) inh_q[i] <= csr_wdata_i[cnt_csr_idx(i)];
    end
  end

  always_comb begin
    cnt_inc    = '0;
    cnt_inc[0] = 1'b1;
    cnt_inc[1] = instr_ret_i;
    for (int k = 0; k < NUM_HPM; k++) cnt_inc[k+2] = |(event_i & evt_q[k]);
    cnt_inc = cnt_inc & ~inh_q & {NCNT{~stopcount_i}};
  end

  for (genvar g = 0; g < NCNT; g++) begin : g_cnt
    cve2_counter #(.WIDTH(CNT_WIDTH)) u_cnt (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .inc_i   (cnt_inc[g]),
      .we_lo_i (we_lo[g]),
      .we_hi_i (we_hi[g]),
      .wdata_i (csr_wdata_i),
      .value_o (cnt_val[g]),
      .wrap_o  (cnt_wrap[g])
    );
  end

`ifdef CVE2_HPM_OVF_IRQ_EN
  logic [NCNT-1:0] ovf_q;

  // A write to either half clears the flag, even in the cycle the counter wraps.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) ovf_q <= '0;
    else       ovf_q <= (ovf_q | cnt_wrap) & ~(we_lo | we_hi);
  end

  assign irq_ovf_o = ~rst_i & (|ovf_q);
`else
  logic unused_wrap;
  assign unused_wrap = ^cnt_wrap;
  assign irq_ovf_o   = 1'b0;
`endif

endmodule

// File: tb/tb_cve2_hpm_unit.sv
// Directed bench for cve2_hpm_unit with an expected-value queue and immediate assertions.
module tb_cve2_hpm_unit;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic [11:0] csr_addr_i = 12'h000;
  logic        csr_we_i = 1'b0;
  logic [31:0] csr_wdata_i = 32'h0;
  logic [31:0] csr_rdata_o;
  logic        csr_hit_o;
  logic        instr_ret_i = 1'b0;
  logic [15:0] event_i = 16'h0;
  logic        stopcount_i = 1'b0;
  logic        irq_ovf_o;

  int checks = 0;
  int failures = 0;
  logic [31:0] exp_q[$];

`ifdef CVE2_HPM_OVF_IRQ_EN
  localparam logic OVF_EXP = 1'b1;
`else
  localparam logic OVF_EXP = 1'b0;
`endif

  cve2_hpm_unit #(.NUM_HPM(2), .CNT_WIDTH(40), .NUM_EVENTS(16)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .csr_addr_i  (csr_addr_i),
    .csr_we_i    (csr_we_i),
    .csr_wdata_i (csr_wdata_i),
    .csr_rdata_o (csr_rdata_o),
    .csr_hit_o   (csr_hit_o),
    .instr_ret_i (instr_ret_i),
    .event_i     (event_i),
    .stopcount_i (stopcount_i),
    .irq_ovf_o   (irq_ovf_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] got);
    logic [31:0] e;
    e = exp_q.pop_front();
    checks++;
    assert (got === e) else begin
      failures++;
      $error("FAIL %s got=%h exp=%h", tag, got, e);
    end
  endtask

  // Combinational read: present address, let it settle, compare.
  task automatic rd(input logic [11:0] a, input logic [31:0] e, input string tag);
    csr_addr_i = a;
    exp_q.push_back(e);
    #1;
    chk(tag, csr_rdata_o);
  endtask

  task automatic hit(input logic [11:0] a, input logic e, input string tag);
    csr_addr_i = a;
    exp_q.push_back(32'(e));
    #1;
    chk(tag, 32'(csr_hit_o));
  endtask

  task automatic irq(input logic e, input string tag);
    exp_q.push_back(32'(e));
    chk(tag, 32'(irq_ovf_o));
  endtask

  // Write commits on the posedge; returns 1ns after it.
  task automatic wr(input logic [11:0] a, input logic [31:0] d, input logic ir);
    @(negedge clk_i);
    csr_addr_i  = a;
    csr_wdata_i = d;
    csr_we_i    = 1'b1;
    instr_ret_i = ir;
    @(posedge clk_i);
    #1;
    csr_we_i    = 1'b0;
    instr_ret_i = 1'b0;
  endtask

  initial begin
    // Reset state
    #2;
    rd(12'hB00, 32'h0, "rst_rdata");
    irq(1'b0, "rst_irq");
    repeat (2) @(negedge clk_i);
    rst_i = 1'b0;
    repeat (10) @(negedge clk_i);
    rd(12'hB00, 32'd10, "idle_mcycle");
    rd(12'hB02, 32'd0,  "idle_minstret");
    rd(12'hB80, 32'd0,  "idle_mcycleh");
    hit(12'hB01, 1'b0, "time_nohit");
    rd(12'h7C0, 32'h0, "foreign_rdata");
    hit(12'h7C0, 1'b0, "foreign_nohit");

    // High-half truncation and wrap
    wr(12'hB80, 32'hFFFF_FFFF, 1'b0);
    rd(12'hB80, 32'h0000_00FF, "mcycleh_trunc");
    wr(12'hB00, 32'hFFFF_FFFF, 1'b0);
    rd(12'hB00, 32'hFFFF_FFFF, "mcycle_allones");
    @(posedge clk_i); #1;
    rd(12'hB00, 32'h0, "wrap_lo");
    rd(12'hB80, 32'h0, "wrap_hi");
    irq(OVF_EXP, "wrap_irq");
    wr(12'hB80, 32'h0, 1'b0);
    irq(1'b0, "irq_clr_on_write");

    // Event counting and inhibit
    wr(12'h323, 32'h5, 1'b0);
    event_i = 16'h4;
    repeat (3) @(posedge clk_i);
    #1 event_i = 16'h2;
    rd(12'hB03, 32'd3, "hpm3_count");
    repeat (2) @(posedge clk_i);
    #1 event_i = 16'h0;
    rd(12'hB03, 32'd3, "hpm3_nomatch");
    rd(12'hB04, 32'd0, "hpm4_idle");
    wr(12'h320, 32'h8, 1'b0);
    event_i = 16'h4;
    repeat (3) @(posedge clk_i);
    #1 event_i = 16'h0;
    rd(12'hB03, 32'd3, "hpm3_inhibited");

    // Write beats increment
    wr(12'hB02, 32'h100, 1'b1);
    rd(12'hB02, 32'h100, "minstret_wr_prio");
    instr_ret_i = 1'b1;
    repeat (2) @(posedge clk_i);
    #1 instr_ret_i = 1'b0;
    rd(12'hB02, 32'h102, "minstret_count");

    // Unimplemented counters and register masks
    wr(12'hB07, 32'h1234, 1'b0);
    rd(12'hB07, 32'h0, "hpm7_rdzero");
    hit(12'hB07, 1'b1, "hpm7_hit");
    wr(12'h327, 32'hFFFF_FFFF, 1'b0);
    rd(12'h327, 32'h0, "evt7_rdzero");
    wr(12'h323, 32'hFFFF_FFFF, 1'b0);
    rd(12'h323, 32'h0000_FFFF, "evt3_mask");
    wr(12'h320, 32'hFFFF_FFFF, 1'b0);
    rd(12'h320, 32'h0000_001D, "inhibit_mask");
    wr(12'hB00, 32'h50, 1'b0);
    repeat (3) @(posedge clk_i);
    #1 rd(12'hB00, 32'h50, "mcycle_inhibited");

    // Debug stopcount freeze
    wr(12'h320, 32'h0, 1'b0);
    stopcount_i = 1'b1;
    wr(12'hB00, 32'h60, 1'b0);
    repeat (3) @(posedge clk_i);
    #1 rd(12'hB00, 32'h60, "stopcount_freeze");
    stopcount_i = 1'b0;
    repeat (2) @(posedge clk_i);
    #1 rd(12'hB00, 32'h62, "stopcount_release");

    // Asynchronous reset between edges while counting with a pending flag
    wr(12'hB80, 32'hFF, 1'b0);
    wr(12'hB00, 32'hFFFF_FFFF, 1'b0);
    event_i = 16'h1;
    @(posedge clk_i); #1;
    irq(OVF_EXP, "wrap2_irq");
    #2 rst_i = 1'b1;
    #1;
    rd(12'hB03, 32'h0, "async_rst_rdata");
    irq(1'b0, "async_rst_irq");
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    event_i = 16'h0;
    rd(12'hB00, 32'h0, "post_rst_mcycle");
    rd(12'hB80, 32'h0, "post_rst_mcycleh");
    rd(12'hB03, 32'h0, "post_rst_hpm3");
    rd(12'h323, 32'h0, "post_rst_evt3");
    rd(12'h320, 32'h0, "post_rst_inhibit");
    irq(1'b0, "post_rst_irq");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
